alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared combinational `alu` (sel, in0, in1 → out). Accepts one operation at a time from either requester via valid/ready, applies round-robin fairness, registers the operands into the ALU and the ALU result into a response register. The response is tagged with the requester ID and a divide-by-zero flag. It sits between the operation sources and the single ALU instance, which it instantiates internally.

---
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational
// ALU. One operation is in flight at a time: IDLE arbitrates, EXEC lets the ALU
// settle on registered operands, RESP holds the tagged result until consumed.

// Combinational ALU: operands zero-extended to RES_W, results modulo 2^RES_W.
module alu #(
    parameter int DATA_WIDTH = 3,
    parameter int RES_W      = 2*DATA_WIDTH+1
) (
    input  logic [2:0]            sel,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    output logic [RES_W-1:0]      out,
    output logic                  dz
);
    logic [RES_W-1:0] a, b;

    // opcode decode; div/mod by zero yield 0 and raise dz
    always_comb begin
        a   = {{(RES_W-DATA_WIDTH){1'b0}}, in0};
        b   = {{(RES_W-DATA_WIDTH){1'b0}}, in1};
        dz  = ((sel == 3'd3) || (sel == 3'd7)) && (in1 == '0);
        out = '0;
        case (sel)
            3'd0: out = a + b;
            3'd1: out = a - b;
            3'd2: out = a * b;
            3'd3: out = dz ? '0 : a / b;
            3'd4: out = a & b;
            3'd5: out = a | b;
            3'd6: out = a ^ b;
            default: out = dz ? '0 : a % b;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int DATA_WIDTH = 3,
    parameter int RES_W      = 2*DATA_WIDTH+1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2:0]            req0_sel,
    input  logic [DATA_WIDTH-1:0] req0_in0,
    input  logic [DATA_WIDTH-1:0] req0_in1,
    input  logic [2:0]            req1_sel,
    input  logic [DATA_WIDTH-1:0] req1_in0,
    input  logic [DATA_WIDTH-1:0] req1_in1,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [RES_W-1:0]      rsp_data,
    output logic                  rsp_dz
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]                  state;
    logic                        last_grant;
    logic                        gnt_id;
    logic                        accept;
    logic [1:0][2:0]             sel_a;
    logic [1:0][DATA_WIDTH-1:0]  in0_a, in1_a;
    logic [2:0]                  op_sel;
    logic [DATA_WIDTH-1:0]       op_in0, op_in1;
    logic                        op_id;
    logic [RES_W-1:0]            alu_out;
    logic                        alu_dz;

    assign sel_a = {req1_sel, req0_sel};
    assign in0_a = {req1_in0, req0_in0};
    assign in1_a = {req1_in1, req0_in1};

    // grant: lone requester wins; on a tie the one not granted last wins
    always_comb begin
        gnt_id    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        req_ready = '0;
        if (state == IDLE && req_valid != 2'b00)
            req_ready = 2'b01 << gnt_id;
        accept    = |(req_valid & req_ready);
    end

    assign rsp_valid = (state == RESP);

    alu #(.DATA_WIDTH(DATA_WIDTH), .RES_W(RES_W)) u_alu (
        .sel (op_sel),
        .in0 (op_in0),
        .in1 (op_in1),
        .out (alu_out),
        .dz  (alu_dz)
    );

    // sequencer: latch operands on accept, capture result after EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_sel     <= '0;
            op_in0     <= '0;
            op_in1     <= '0;
            op_id      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_sel     <= sel_a[gnt_id];
                    op_in0     <= in0_a[gnt_id];
                    op_in1     <= in1_a[gnt_id];
                    op_id      <= gnt_id;
                    last_grant <= gnt_id;
                    state      <= EXEC;
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    rsp_dz   <= alu_dz;
                    rsp_id   <= op_id;
                    state    <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, corner sequences (fairness,
// backpressure, reset mid-op), exhaustive opcode sweep and random traffic.
module tb_alu_arbiter;
    localparam int DW = 3;
    localparam int RW = 2*DW+1;

    typedef struct packed {
        logic [2:0]    s;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    typedef struct {
        logic [1:0]    v;
        op_t           o;
        int            id;
        logic [RW-1:0] d;
        logic          dz;
    } vec_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [1:0]    req_valid = 0;
    logic [1:0]    req_ready;
    logic [2:0]    req0_sel = 0, req1_sel = 0;
    logic [DW-1:0] req0_in0 = 0, req0_in1 = 0, req1_in0 = 0, req1_in1 = 0;
    logic          rsp_valid;
    logic          rsp_ready = 1;
    logic          rsp_id;
    logic [RW-1:0] rsp_data;
    logic          rsp_dz;

    int total = 0;
    int bad = 0;
    int last_id = 1;
    int twohot = 0;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_sel(req0_sel), .req0_in0(req0_in0), .req0_in1(req0_in1),
        .req1_sel(req1_sel), .req1_in0(req1_in0), .req1_in1(req1_in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_dz(rsp_dz)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (req_ready == 2'b11) twohot++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // reference: opcode table evaluated with plain integer arithmetic
    function automatic logic [RW:0] model(input op_t o);
        int a, b, r;
        logic z;
        a = int'(o.a); b = int'(o.b); z = 1'b0; r = 0;
        case (o.s)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd3: if (b == 0) z = 1'b1; else r = a / b;
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: if (b == 0) z = 1'b1; else r = a % b;
        endcase
        return {z, r[RW-1:0]};
    endfunction

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b11) return (last_id == 0) ? 1 : 0;
        return v[0] ? 0 : 1;
    endfunction

    task automatic drive(input op_t o0, input op_t o1);
        req0_sel = o0.s; req0_in0 = o0.a; req0_in1 = o0.b;
        req1_sel = o1.s; req1_in0 = o1.a; req1_in1 = o1.b;
    endtask

    task automatic do_reset();
        rst_n = 0; req_valid = 0; rsp_ready = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        last_id = 1;
    endtask

    // one full transaction; called right after a posedge (+#1) with state IDLE
    task automatic issue(input logic [1:0] v, input op_t o0, input op_t o1,
                         input int exp_id, input logic [RW-1:0] exp_d,
                         input logic exp_dz, input int bp, output int waited);
        int cyc;
        logic [RW-1:0] held;
        drive(o0, o1);
        req_valid = v;
        cyc = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        waited = cyc;
        chk("grant", req_ready, 32'(2'b01 << exp_id));
        if (req_ready == 2'b00) begin
            req_valid = 0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 0;
        last_id = exp_id;
        @(negedge clk);
        chk("exec_valid", rsp_valid, 0);
        chk("exec_ready", req_ready, 0);
        rsp_ready = (bp == 0);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_dz", rsp_dz, exp_dz);
        held = rsp_data;
        for (int i = 0; i < bp; i++) begin
            req_valid = 2'b11;
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, held);
            chk("bp_ready", req_ready, 0);
        end
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        vec_t vt[10];
        op_t  o0, o1, rnd;
        logic [RW:0] m;
        logic [1:0] v;
        int w, id, seen;

        vt[0] = '{2'b01, '{3'd0, 3'd5, 3'd6}, 0, 7'd11,   1'b0};
        vt[1] = '{2'b01, '{3'd1, 3'd2, 3'd5}, 0, 7'h7D,   1'b0};
        vt[2] = '{2'b10, '{3'd3, 3'd6, 3'd0}, 1, 7'd0,    1'b1};
        vt[3] = '{2'b10, '{3'd7, 3'd7, 3'd3}, 1, 7'd1,    1'b0};
        vt[4] = '{2'b01, '{3'd2, 3'd7, 3'd7}, 0, 7'd49,   1'b0};
        vt[5] = '{2'b10, '{3'd4, 3'd6, 3'd3}, 1, 7'd2,    1'b0};
        vt[6] = '{2'b01, '{3'd5, 3'd4, 3'd3}, 0, 7'd7,    1'b0};
        vt[7] = '{2'b10, '{3'd6, 3'd5, 3'd3}, 1, 7'd6,    1'b0};
        vt[8] = '{2'b01, '{3'd3, 3'd7, 3'd2}, 0, 7'd3,    1'b0};
        vt[9] = '{2'b10, '{3'd7, 3'd5, 3'd0}, 1, 7'd0,    1'b1};

        do_reset();
        @(posedge clk); #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_dz", rsp_dz, 0);
        chk("rst_ready", req_ready, 0);

        // directed vectors
        for (int i = 0; i < 10; i++) begin
            rnd = op_t'($urandom);
            if (vt[i].v[0]) issue(vt[i].v, vt[i].o, rnd, vt[i].id, vt[i].d, vt[i].dz, 0, w);
            else            issue(vt[i].v, rnd, vt[i].o, vt[i].id, vt[i].d, vt[i].dz, 0, w);
        end

        // tie fairness from reset: grants alternate starting with requester 0
        do_reset();
        @(posedge clk); #1;
        o0 = '{3'd0, 3'd1, 3'd2};
        o1 = '{3'd2, 3'd3, 3'd3};
        for (int k = 0; k < 8; k++) begin
            m = model((k % 2) ? o1 : o0);
            issue(2'b11, o0, o1, k % 2, m[RW-1:0], m[RW], 0, w);
        end
        chk("twohot", twohot, 0);

        // backpressure for 5 cycles, then the next request goes in at once
        o0 = '{3'd1, 3'd3, 3'd6};
        m = model(o0);
        issue(2'b01, o0, o0, pick(2'b01), m[RW-1:0], m[RW], 5, w);
        o1 = '{3'd2, 3'd5, 3'd6};
        m = model(o1);
        issue(2'b10, o0, o1, pick(2'b10), m[RW-1:0], m[RW], 0, w);
        chk("post_bp_wait", w, 0);

        // reset during EXEC discards the transaction
        o0 = '{3'd0, 3'd3, 3'd4};
        drive(o0, o0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("rst_op_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_dz", rsp_dz, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        last_id = 1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_rsp_after_rst", seen, 0);
        @(posedge clk); #1;
        o1 = '{3'd6, 3'd7, 3'd1};
        m = model(o0);
        issue(2'b11, o0, o1, 0, m[RW-1:0], m[RW], 0, w);

        // exhaustive sweep, alternating requesters
        for (int i = 0; i < 512; i++) begin
            rnd = op_t'(i[8:0]);
            id = i % 2;
            m = model(rnd);
            if (id == 0) issue(2'b01, rnd, '0, 0, m[RW-1:0], m[RW], 0, w);
            else         issue(2'b10, '0, rnd, 1, m[RW-1:0], m[RW], 0, w);
        end

        // random traffic with ties and occasional backpressure
        for (int i = 0; i < 200; i++) begin
            v = 2'($urandom_range(1, 3));
            o0 = op_t'($urandom);
            o1 = op_t'($urandom);
            id = pick(v);
            m = model(id ? o1 : o0);
            issue(v, o0, o1, id, m[RW-1:0], m[RW], ($urandom_range(0, 3) == 0) ? 2 : 0, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
